// File: rtl/avg_sample_fifo.sv
// First-word-fall-through sample FIFO behind the moving-average filter.
// The head sample, occupancy and overflow status are all held in registers.
module avg_sample_fifo #(
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 12
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic                       flush,
    input  logic                       in_pulse,
    input  logic [15:0]                din,
    input  logic                       m_ready,
    output logic                       m_valid,
    output logic [15:0]                m_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       almost_full,
    output logic                       overflow,
    output logic [7:0]                 ovf_cnt,
    input  logic                       clr_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_L = LW'(DEPTH);
    localparam logic [LW-1:0] AF_L   = LW'(AF_LEVEL);

    logic [15:0]   mem_r [DEPTH];
    logic [AW-1:0] rd_ptr_r, wr_ptr_r, rd_ptr_nxt_s, wr_ptr_nxt_s;
    logic [LW-1:0] level_r, level_nxt_s;
    logic [15:0]   m_data_r, m_data_nxt_s;
    logic          m_valid_r, almost_full_r, overflow_r;
    logic [7:0]    ovf_cnt_r;
    logic          push_s, pop_s, full_s, wr_en_s, drop_s;

    // Accept/drop decisions, next pointers, next occupancy and next head sample
    always_comb begin
        push_s       = enable & in_pulse;
        pop_s        = m_valid_r & m_ready;
        full_s       = (level_r == FULL_L);
        wr_en_s      = push_s & (~full_s | pop_s) & ~flush;
        drop_s       = push_s & full_s & ~pop_s & ~flush;
        rd_ptr_nxt_s = rd_ptr_r;
        wr_ptr_nxt_s = wr_ptr_r;
        level_nxt_s  = level_r;
        m_data_nxt_s = m_data_r;
        if (flush) begin
            rd_ptr_nxt_s = {AW{1'b0}};
            wr_ptr_nxt_s = {AW{1'b0}};
            level_nxt_s  = {LW{1'b0}};
        end else begin
            rd_ptr_nxt_s = pop_s ? rd_ptr_r + AW'(1) : rd_ptr_r;
            wr_ptr_nxt_s = wr_en_s ? wr_ptr_r + AW'(1) : wr_ptr_r;
            case ({wr_en_s, pop_s})
                2'b10:   level_nxt_s = level_r + LW'(1);
                2'b01:   level_nxt_s = level_r - LW'(1);
                default: level_nxt_s = level_r;
            endcase
            // A sample written into the slot that becomes the head must bypass the RAM
            if (level_nxt_s == {LW{1'b0}}) begin
                m_data_nxt_s = m_data_r;
            end else if (wr_en_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
                m_data_nxt_s = din;
            end else begin
                m_data_nxt_s = mem_r[rd_ptr_nxt_s];
            end
        end
    end

    // Sample storage; contents are not reset
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers, occupancy and registered head/status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_r      <= {AW{1'b0}};
            wr_ptr_r      <= {AW{1'b0}};
            level_r       <= {LW{1'b0}};
            m_valid_r     <= 1'b0;
            m_data_r      <= 16'h0000;
            almost_full_r <= 1'b0;
        end else begin
            rd_ptr_r      <= rd_ptr_nxt_s;
            wr_ptr_r      <= wr_ptr_nxt_s;
            level_r       <= level_nxt_s;
            m_valid_r     <= (level_nxt_s != {LW{1'b0}});
            m_data_r      <= m_data_nxt_s;
            almost_full_r <= (level_nxt_s >= AF_L);
        end
    end

    // Sticky overflow flag and saturating drop counter; a clear loses to a same-cycle drop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_r <= 1'b0;
            ovf_cnt_r  <= 8'd0;
        end else if (clr_ovf) begin
            overflow_r <= drop_s;
            ovf_cnt_r  <= drop_s ? 8'd1 : 8'd0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
            ovf_cnt_r  <= (ovf_cnt_r == 8'hFF) ? 8'hFF : ovf_cnt_r + 8'd1;
        end else begin
            overflow_r <= overflow_r;
            ovf_cnt_r  <= ovf_cnt_r;
        end
    end

    assign m_valid     = m_valid_r;
    assign m_data      = m_data_r;
    assign level       = level_r;
    assign almost_full = almost_full_r;
    assign overflow    = overflow_r;
    assign ovf_cnt     = ovf_cnt_r;

endmodule

// File: tb/tb_avg_sample_fifo.sv
// Bench for avg_sample_fifo: directed scenarios plus random traffic, all
// compared against a queue-based reference model of the FIFO behaviour.
module tb_avg_sample_fifo;

    localparam int DEPTH = 16;
    localparam int AF    = 12;

    logic        clk = 1'b0;
    logic        rst_n, enable, flush, in_pulse, m_ready, clr_ovf;
    logic [15:0] din;
    logic        m_valid, almost_full, overflow;
    logic [15:0] m_data;
    logic [4:0]  level;
    logic [7:0]  ovf_cnt;

    logic [15:0] q[$];
    bit          mdl_ovf;
    int          mdl_cnt;
    int          n_checks = 0;
    int          n_fail   = 0;

    avg_sample_fifo #(.DEPTH(DEPTH), .AF_LEVEL(AF)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .flush(flush),
        .in_pulse(in_pulse), .din(din), .m_ready(m_ready),
        .m_valid(m_valid), .m_data(m_data), .level(level),
        .almost_full(almost_full), .overflow(overflow),
        .ovf_cnt(ovf_cnt), .clr_ovf(clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        check_eq("m_valid", 32'(m_valid), 32'(q.size() != 0));
        check_eq("level", 32'(level), 32'(q.size()));
        check_eq("almost_full", 32'(almost_full), 32'(q.size() >= AF));
        check_eq("overflow", 32'(overflow), 32'(mdl_ovf));
        check_eq("ovf_cnt", 32'(ovf_cnt), 32'(mdl_cnt));
        if (q.size() != 0) check_eq("m_data", 32'(m_data), 32'(q[0]));
    endtask

    task automatic drive(input bit en, input bit ip, input logic [15:0] d,
                         input bit rdy, input bit fl, input bit clr);
        enable = en; in_pulse = ip; din = d; m_ready = rdy; flush = fl; clr_ovf = clr;
    endtask

    // Advance the model by one edge from the current inputs, then compare.
    task automatic step();
        bit push, pop, full, drop;
        push = enable && in_pulse;
        pop  = (q.size() != 0) && m_ready;
        drop = 1'b0;
        if (flush) begin
            q.delete();
        end else begin
            full = (q.size() == DEPTH);
            if (pop) void'(q.pop_front());
            if (push) begin
                if (full && !pop) drop = 1'b1;
                else q.push_back(din);
            end
        end
        if (clr_ovf) begin
            mdl_ovf = drop;
            mdl_cnt = drop ? 1 : 0;
        end else if (drop) begin
            mdl_ovf = 1'b1;
            if (mdl_cnt < 255) mdl_cnt++;
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle(input bit rdy, input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, 1'b0, 16'h0, rdy, 1'b0, 1'b0);
            step();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        mdl_ovf = 1'b0;
        mdl_cnt = 0;
        #12;
        check_all();
        check_eq("rst_m_data", 32'(m_data), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // single negative sample
        drive(1'b1, 1'b1, 16'hFFFB, 1'b0, 1'b0, 1'b0);
        step();
        check_eq("single_data", 32'(m_data), 32'h0000FFFB);
        check_eq("single_level", 32'(level), 32'd1);
        idle(1'b1, 1);
        check_eq("single_empty", 32'(m_valid), 32'd0);

        // fill 1..16, then three drops
        for (int i = 1; i <= DEPTH; i++) begin
            drive(1'b1, 1'b1, 16'(i), 1'b0, 1'b0, 1'b0);
            step();
            check_eq("af_edge", 32'(almost_full), 32'(i >= 12));
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 16'(100 + i), 1'b0, 1'b0, 1'b0);
            step();
        end
        check_eq("ovf3_cnt", 32'(ovf_cnt), 32'd3);
        check_eq("ovf3_head", 32'(m_data), 32'd1);
        drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        step();
        check_eq("clr_cnt", 32'(ovf_cnt), 32'd0);

        // full concurrent push/pop
        drive(1'b1, 1'b1, 16'd99, 1'b1, 1'b0, 1'b0);
        step();
        check_eq("fullpp_level", 32'(level), 32'd16);
        check_eq("fullpp_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            if (i == DEPTH - 1) check_eq("last_out", 32'(m_data), 32'd99);
            drive(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
            step();
        end

        // saturating drop counter
        for (int i = 0; i < DEPTH + 300; i++) begin
            drive(1'b1, 1'b1, 16'(i), 1'b0, 1'b0, 1'b0);
            step();
        end
        check_eq("sat_cnt", 32'(ovf_cnt), 32'd255);

        // flush plus push at level 5
        drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
        step();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 16'(200 + i), 1'b0, 1'b0, 1'b0);
            step();
        end
        drive(1'b1, 1'b1, 16'h1234, 1'b1, 1'b1, 1'b0);
        step();
        check_eq("flush_level", 32'(level), 32'd0);
        check_eq("flush_ovf", 32'(overflow), 32'd1);
        drive(1'b1, 1'b1, 16'h4321, 1'b0, 1'b0, 1'b0);
        step();

        // asynchronous reset at level 7 with overflow set
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b1, 16'(300 + i), 1'b0, 1'b0, 1'b0);
            step();
        end
        check_eq("pre_rst_level", 32'(level), 32'd7);
        #2;
        rst_n = 1'b0;
        #1;
        q.delete();
        mdl_ovf = 1'b0;
        mdl_cnt = 0;
        check_all();
        check_eq("rst_mid_data", 32'(m_data), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 1'b1, 16'h7777, 1'b0, 1'b0, 1'b0);
        step();
        check_eq("en_low_level", 32'(level), 32'd0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 6, 16'($urandom),
                  $urandom_range(0, 9) < 4, $urandom_range(0, 199) == 0,
                  $urandom_range(0, 99) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
